// File: rtl/lasd_rf_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package lasd_rf_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_AW    = $clog2(DEF_DEPTH);

    typedef logic [DEF_AW-1:0]    rf_addr_t;
    typedef logic [DEF_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits, registered pending-write count and sticky write-back error.
module rf_scoreboard
    import lasd_rf_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_addr,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          busy1,
    output logic          busy2,
    output logic [AW:0]   pending_cnt,
    output logic          err
);

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [AW:0]      r_cnt;
    logic             r_err;
    logic             w_set;
    logic             w_clr;
    logic             w_inc;
    logic             w_dec;

    assign w_set = rsv_en && (rsv_addr != '0);
    assign w_clr = we && (wa != '0);

    // A reservation on the same edge as the write-back wins: the new producer is pending.
    assign w_inc = w_set && !r_busy[rsv_addr];
    assign w_dec = w_clr && r_busy[wa] && !(w_set && (rsv_addr == wa));

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) w_busy_nxt[wa] = 1'b0;
        if (w_set) w_busy_nxt[rsv_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_inc && !w_dec)
                r_cnt <= r_cnt + CNT_ONE;
            else if (w_dec && !w_inc)
                r_cnt <= r_cnt - CNT_ONE;
            if (w_clr && !r_busy[wa])
                r_err <= 1'b1;
        end
    end

    assign busy1 = (r_busy[ra1] && !(we && (wa == ra1))) || (w_set && (rsv_addr == ra1));
    assign busy2 = (r_busy[ra2] && !(we && (wa == ra2))) || (w_set && (rsv_addr == ra2));

    assign pending_cnt = r_cnt;
    assign err         = r_err;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with r0 hardwired to zero, write-to-read bypass and RAW-hazard scoreboard.
module regfile_scoreboard
    import lasd_rf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy1,
    output logic             busy2,
    output logic [AW:0]      pending_cnt,
    output logic             err
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_byp1;
    logic             w_byp2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (we && (wa != '0)) begin
            r_mem[wa] <= wd;
        end
    end

    assign w_byp1 = we && (wa == ra1) && (ra1 != '0);
    assign w_byp2 = we && (wa == ra2) && (ra2 != '0);

    assign rd1 = w_byp1 ? wd : ((ra1 == '0) ? '0 : r_mem[ra1]);
    assign rd2 = w_byp2 ? wd : ((ra2 == '0) ? '0 : r_mem[ra2]);

    rf_scoreboard #(
        .DEPTH (DEPTH)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .wa          (wa),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .ra1         (ra1),
        .ra2         (ra2),
        .busy1       (busy1),
        .busy2       (busy2),
        .pending_cnt (pending_cnt),
        .err         (err)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with hand-computed expectations (WIDTH=8, DEPTH=8).
module tb_regfile_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       rsv_en;
    logic [2:0] rsv_addr;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic       busy1;
    logic       busy2;
    logic [3:0] pending_cnt;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .ra1         (ra1),
        .ra2         (ra2),
        .rd1         (rd1),
        .rd2         (rd2),
        .busy1       (busy1),
        .busy2       (busy2),
        .pending_cnt (pending_cnt),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rsv_en = 1'b0; wa = '0; rsv_addr = '0; wd = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        ra1 = '0; ra2 = '0;
        #12;
        chk("rst_cnt",   {4'b0, pending_cnt}, 8'd0);
        chk("rst_err",   {7'b0, err},         8'd0);
        chk("rst_rd1",   rd1,                 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // write r3, then reset asynchronously between edges
        we = 1'b1; wa = 3'd3; wd = 8'hAA; ra1 = 3'd3;
        tick();
        idle();
        chk("wr3_rd1",   rd1,                 8'hAA);
        chk("wr3_err",   {7'b0, err},         8'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_rd1",  rd1,                 8'h00);
        chk("arst_cnt",  {4'b0, pending_cnt}, 8'd0);
        chk("arst_err",  {7'b0, err},         8'd0);
        @(negedge clk);
        reset = 1'b0;

        // r0 writes are ignored and never flag err
        we = 1'b1; wa = 3'd0; wd = 8'h5A; ra1 = 3'd0;
        #1;
        chk("r0_byp_rd1", rd1,                8'h00);
        chk("r0_busy1",  {7'b0, busy1},       8'd0);
        tick();
        idle();
        chk("r0_rd1",    rd1,                 8'h00);
        chk("r0_err",    {7'b0, err},         8'd0);

        // reserve r5, then write it back with bypass
        rsv_en = 1'b1; rsv_addr = 3'd5;
        tick();
        idle();
        ra1 = 3'd5;
        #1;
        chk("r5_busy1",  {7'b0, busy1},       8'd1);
        chk("r5_cnt",    {4'b0, pending_cnt}, 8'd1);
        we = 1'b1; wa = 3'd5; wd = 8'h3C;
        #1;
        chk("r5_byp_rd1", rd1,                8'h3C);
        chk("r5_byp_busy", {7'b0, busy1},     8'd0);
        tick();
        idle();
        chk("r5_wb_cnt", {4'b0, pending_cnt}, 8'd0);
        chk("r5_wb_rd1", rd1,                 8'h3C);
        chk("r5_wb_err", {7'b0, err},         8'd0);

        // reserve r4; then reserve r2 and write r4 on one edge
        rsv_en = 1'b1; rsv_addr = 3'd4;
        tick();
        chk("r4_cnt",    {4'b0, pending_cnt}, 8'd1);
        idle();
        rsv_en = 1'b1; rsv_addr = 3'd2;
        we = 1'b1; wa = 3'd4; wd = 8'h77;
        tick();
        idle();
        ra1 = 3'd2; ra2 = 3'd4;
        #1;
        chk("mix_cnt",   {4'b0, pending_cnt}, 8'd1);
        chk("mix_busy2r", {7'b0, busy1},      8'd1);
        chk("mix_busy4r", {7'b0, busy2},      8'd0);
        chk("mix_rd4",   rd2,                 8'h77);
        chk("mix_err",   {7'b0, err},         8'd0);

        // reserve r6; then reserve and write r6 together
        rsv_en = 1'b1; rsv_addr = 3'd6;
        tick();
        chk("r6_cnt",    {4'b0, pending_cnt}, 8'd2);
        rsv_en = 1'b1; rsv_addr = 3'd6;
        we = 1'b1; wa = 3'd6; wd = 8'h11; ra1 = 3'd6;
        #1;
        chk("r6_same_busy1", {7'b0, busy1},   8'd1);
        chk("r6_same_rd1", rd1,               8'h11);
        tick();
        idle();
        chk("r6_rd1",    rd1,                 8'h11);
        chk("r6_busy1",  {7'b0, busy1},       8'd1);
        chk("r6_cnt2",   {4'b0, pending_cnt}, 8'd2);
        chk("r6_err",    {7'b0, err},         8'd0);

        // write r7 unreserved sets sticky err
        we = 1'b1; wa = 3'd7; wd = 8'h01;
        tick();
        idle();
        ra1 = 3'd7; ra2 = 3'd7;
        #1;
        chk("r7_err",    {7'b0, err},         8'd1);
        chk("r7_rd1",    rd1,                 8'h01);
        chk("r7_rd2",    rd2,                 8'h01);
        chk("r7_cnt",    {4'b0, pending_cnt}, 8'd2);

        // legal write-back to busy r2: err stays, count drops
        we = 1'b1; wa = 3'd2; wd = 8'h22;
        tick();
        idle();
        ra1 = 3'd2;
        #1;
        chk("r2_err",    {7'b0, err},         8'd1);
        chk("r2_cnt",    {4'b0, pending_cnt}, 8'd1);
        chk("r2_rd1",    rd1,                 8'h22);

        // reset clears err, busy bits, count and storage
        ra1 = 3'd6;
        reset = 1'b1;
        #1;
        chk("fin_err",   {7'b0, err},         8'd0);
        chk("fin_cnt",   {4'b0, pending_cnt}, 8'd0);
        chk("fin_rd6",   rd1,                 8'h00);
        chk("fin_busy6", {7'b0, busy1},       8'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised multi-register file for the datapath, with WIDTH-bit data, DEPTH entries, two combinational read ports and one write port.
- Register 0 is hardwired to zero.
- Adds what the earlier register file lacked: asynchronous clear, write-to-read bypass, and per-register busy (scoreboard) bits with a pending-write counter.
- Lets the control unit detect read-after-write hazards before a result is written back.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 8, number of registers; power of two, >=2.
- AW, $clog2(DEPTH), address width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- we  input  1  write-back enable.
- wa  input  AW  write-back address.
- wd  input  WIDTH  write-back data.
- rsv_en  input  1  reserve destination (instruction issued, result pending).
- rsv_addr  input  AW  register being reserved.
- ra1  input  AW  read address, port 1.
- ra2  input  AW  read address, port 2.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.
- busy1  output  1  ra1 has a pending write.
- busy2  output  1  ra2 has a pending write.
- pending_cnt  output  AW+1  number of busy registers.
- err  output  1  sticky: write-back to a non-reserved register.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset, asserted at any time including mid-operation:
  - All registers are cleared to 0, all busy bits to 0, pending_cnt to 0, err to 0.
  - Takes effect immediately, with no clock needed.
  - Any reservation or write in that cycle is discarded.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and reservations to address 0 are ignored.
  - Writes to address 0 never set err.
- Write, at posedge clk, when we=1 and wa!=0:
  - mem[wa] <= wd.
  - busy[wa] <= 0, unless the reservation rule below applies.
- Reservation, at posedge clk, when rsv_en=1 and rsv_addr!=0: busy[rsv_addr] <= 1.
  - Reserving an already busy register is legal; the bit stays 1 and the count does not change.
- Simultaneous write and reservation to the same nonzero address:
  - The data is written.
  - busy stays/becomes 1, because the new producer wins.
  - pending_cnt follows the final busy state.
- Reads are combinational with bypass:
  - rdN = wd if we=1 and wa==raN and raN!=0; else rdN = mem[raN].
  - busyN = busy[raN] & ~(we & wa==raN).
  - busyN stays 1 if the same cycle also reserves raN (rsv_en & rsv_addr==raN & raN!=0).
  - Both ports may read the same address.
- pending_cnt is registered and equals the popcount of the busy bits after each edge.
  - It is maintained incrementally: +1 for a 0->1 transition, -1 for a 1->0 transition, both possible in one cycle on different addresses.
  - Range 0..DEPTH-1. It never wraps; reaching that range is guaranteed by the busy-bit rules.
- err:
  - Set at posedge when we=1, wa!=0 and busy[wa]=0 (pre-edge value).
  - The write still completes.
  - Cleared only by reset.

Decomposition:
- Shared package lasd_rf_pkg holds:
  - the default WIDTH/DEPTH constants;
  - typedef rf_addr_t = logic [AW-1:0] for default DEPTH;
  - typedef rf_data_t.
- One natural sub-module, rf_scoreboard: busy bits, pending_cnt and err.
- The top level holds the storage array and the bypass muxes.

Test Plan:
- Reset with WIDTH=8, DEPTH=8: write 8'hAA to r3, then assert reset between edges -> rd1(ra1=3)=0 immediately, pending_cnt=0, err=0.
- Write 8'h5A to r0, read ra1=0 -> rd1=0, busy1=0, err stays 0.
- Reserve r5 -> next cycle busy1(ra1=5)=1 and pending_cnt=1. Then we=1, wa=5, wd=8'h3C with ra1=5:
  - same cycle: rd1=8'h3C (bypass), busy1=0;
  - after the edge: pending_cnt=0, rd1=8'h3C from storage.
- Same edge: reserve r2 and write r4, where r4 was reserved earlier -> pending_cnt unchanged at 1, busy[2]=1, busy[4]=0.
- Reserve r6 and write r6=8'h11 on the same edge (r6 previously busy) -> mem[6]=8'h11, busy[6]=1, pending_cnt unchanged.
- Write r7=8'h01 with r7 not reserved -> err=1 after the edge and stays 1 through later writes; mem[7]=8'h01; reset clears err.
